uart_tx_queue: RTL
==================

// Module: uart_tx_queue
// PURPOSE
//  Byte FIFO and issue controller placed directly upstream of uart_tx.
//  Producers push bytes with a valid/ready handshake. The block pops one byte at a time,
//  pulses tx_dv for one clock, and holds tx_byte stable until uart_tx reports tx_done.
//  This replaces the single-shot switch trigger with back-to-back streaming of queued bytes.
// PARAMETERS
//  DEPTH        16      FIFO entries; power of 2, >=2; ADDR_W = $clog2(DEPTH) (localparam)
//  DONE_TIMEOUT 4096    max cycles to wait for tx_done after tx_dv; must be > 10*CLKS_PER_BIT
// PORTS
//  ui_clk      in   1         single clock; all logic on posedge
//  ui_rst      in   1         synchronous, active-high reset
//  s_data      in   8         byte to enqueue
//  s_valid     in   1         s_data valid
//  s_ready     out  1         FIFO not full; byte accepted on s_valid & s_ready
//  tx_dv       out  1         1-cycle start pulse to uart_tx i_Tx_DV
//  tx_byte     out  8         byte to uart_tx i_Tx_Byte; stable from tx_dv until tx_done
//  tx_active   in   1         from uart_tx o_Tx_Active
//  tx_done     in   1         from uart_tx o_Tx_Done
//  level       out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
//  overflow    out  1         sticky: s_valid seen while full (byte dropped)
//  timeout     out  1         sticky: tx_done not seen within DONE_TIMEOUT cycles
//  sent_count  out  16        bytes completed (tx_done received); see CONFIGURATION
// BEHAVIOUR
//  Reset: FIFO pointers=0, level=0, s_ready=1, tx_dv=0, tx_byte=0, overflow=0, timeout=0,
//   sent_count=0, state=IDLE. Reset mid-frame discards the in-flight byte. uart_tx has no
//   reset, so IDLE must not issue while tx_active=1.
//  FIFO: registered storage; wr_ptr/rd_ptr ADDR_W+1 bits; full = MSBs differ and low bits
//   equal; empty = pointers equal. Pointers wrap modulo 2*DEPTH.
//   s_ready = ~full, combinational from registered pointers.
//  Push and pop in the same cycle: both take effect and level is unchanged. When full,
//   a same-cycle pop does not make s_ready high in that cycle.
//  overflow sets when s_valid & full. It clears only on ui_rst.
//  FSM (state encoding is free):
//   IDLE  : if ~empty & ~tx_active -> pop head into tx_byte, tx_dv<=1, go START
//   START : tx_dv<=0, clear wait counter, go WAIT
//   WAIT  : count cycles. On tx_done -> sent_count+1 (wraps at 16 bits), go IDLE.
//           If count reaches DONE_TIMEOUT-1 -> timeout<=1, go IDLE (byte treated as lost).
//  Latency: a byte pushed at edge k into an empty, idle queue -> tx_dv high after edge k+1.
//  Back-to-back: tx_done seen at edge j -> next tx_dv high after edge j+1 if not empty.
//  tx_done outside WAIT is ignored. tx_dv is never high in two consecutive cycles.
//  tx_byte changes only on a pop or on reset.
// CONFIGURATION
//  UART_TXQ_STATS_EN defined: sent_count counter implemented as described.
//  UART_TXQ_STATS_EN undefined: sent_count tied to 16'd0, no counter logic.
//   overflow and timeout are always present.
// TESTING (ui_clk 100 MHz, uart_tx/uart_rx loopback, CLKS_PER_BIT=100)
//  T1 push 8'h06 into empty queue -> tx_dv 1 cycle, 2 clocks after accept; loopback rx
//     byte=8'h06; level 1->0; sent_count=1.
//  T2 burst push 8'h11,8'h9D,8'hA5 on consecutive cycles -> received in order;
//     each tx_dv exactly 2 clocks after prior tx_done; level peaks at 2 or 3.
//  T3 push 17 bytes with tx_active forced 1 -> s_ready=0 at level=16; 17th sets overflow=1;
//     release tx_active -> exactly 16 bytes sent.
//  T4 tx_done held 0 after tx_dv (uart_tx stubbed) -> timeout=1 after DONE_TIMEOUT cycles;
//     FSM returns to IDLE and issues the next queued byte.
//  T5 assert ui_rst for 1 cycle in WAIT with level=3 -> level=0, tx_dv=0, flags=0;
//     no tx_dv until tx_active falls.
//  T6 build without UART_TXQ_STATS_EN -> repeat T2; sent_count stays 0; other outputs identical.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus issue controller sitting directly in front of uart_tx.
// Producers push bytes over a valid/ready handshake. The controller pops one byte at a time,
// pulses tx_dv for a single clock, and holds tx_byte until uart_tx reports tx_done.
// A missing tx_done is bounded by DONE_TIMEOUT cycles and flagged in the sticky timeout bit.
// Optional feature macro: UART_TXQ_STATS_EN enables the 16-bit sent_count counter; without it
// sent_count reads as zero and no counter logic exists.
module uart_tx_queue #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned DONE_TIMEOUT = 4096,
   localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
   input  logic              ui_clk,
   input  logic              ui_rst,
   // producer side
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   // uart_tx side
   output logic              tx_dv,
   output logic [7:0]        tx_byte,
   input  logic              tx_active,
   input  logic              tx_done,
   // status
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              timeout,
   output logic [15:0]       sent_count
);

   // Wait counter only needs to reach DONE_TIMEOUT-1.
   localparam int unsigned CNT_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWait
   } state_e;

   // ------------------------------------------------------------------------------------------
   // FIFO storage and pointers
   // ------------------------------------------------------------------------------------------
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]      mem_q [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   state_e          state_q;
   logic            tx_dv_q;
   logic [7:0]      tx_byte_q;
   logic            timeout_q;
   logic [CNT_W-1:0] wait_cnt_q;
   logic            overflow_q;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   // s_ready depends only on registered pointers, so a same-cycle pop cannot raise it.
   assign s_ready = ~full;
   assign push    = s_valid & ~full;

   // uart_tx is never reset, so a frame may still be running after our reset: wait it out.
   assign pop = (state_q == StIdle) & ~empty & ~tx_active;

   assign level = wr_ptr_q - rd_ptr_q;

   // Next-state pointers; each advances by one on its own handshake.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(1);
      end
   end

   // Pointer registers, cleared by reset (which also empties the queue).
   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Byte storage; contents are don't-care until written, so no reset is needed.
   always_ff @(posedge ui_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= s_data;
      end
   end

   // Sticky overflow: a byte was offered while the queue was full and got dropped.
   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         overflow_q <= 1'b0;
      end else if (s_valid && full) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;

   // ------------------------------------------------------------------------------------------
   // Issue controller
   // ------------------------------------------------------------------------------------------

   // Issue FSM with registered outputs: pop -> one-cycle tx_dv -> wait for tx_done or timeout.
   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         state_q    <= StIdle;
         tx_dv_q    <= 1'b0;
         tx_byte_q  <= 8'd0;
         timeout_q  <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  tx_byte_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                  tx_dv_q   <= 1'b1;
                  state_q   <= StStart;
               end
            end
            StStart: begin
               // tx_done is ignored here; the frame has only just been requested.
               tx_dv_q    <= 1'b0;
               wait_cnt_q <= '0;
               state_q    <= StWait;
            end
            StWait: begin
               if (tx_done) begin
                  state_q <= StIdle;
               end else if (wait_cnt_q == CNT_LAST) begin
                  // Give up on this byte so the queue keeps draining.
                  timeout_q <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               tx_dv_q <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign tx_dv   = tx_dv_q;
   assign tx_byte = tx_byte_q;
   assign timeout = timeout_q;

   // ------------------------------------------------------------------------------------------
   // Optional statistics
   // ------------------------------------------------------------------------------------------
`ifdef UART_TXQ_STATS_EN
   logic        done_evt;
   logic [15:0] sent_count_q;

   // Only a tx_done that closes an outstanding frame counts as a completed byte.
   assign done_evt = (state_q == StWait) & tx_done;

   // Completed-byte counter, wraps at 16 bits.
   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         sent_count_q <= 16'd0;
      end else if (done_evt) begin
         sent_count_q <= sent_count_q + 16'd1;
      end
   end

   assign sent_count = sent_count_q;
`else
   assign sent_count = 16'd0;
`endif

endmodule
